// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared encodings for the Simple CPU V1 control sequencer
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST     = 3'b000,
        ST_FETCH   = 3'b001,
        ST_LOAD_IR = 3'b010,
        ST_DECODE  = 3'b011,
        ST_MEM_RD  = 3'b100,
        ST_MEM_WR  = 3'b101,
        ST_EXEC    = 3'b110,
        ST_HALT    = 3'b111
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_RSC = 4'hC;
    localparam logic [3:0] OP_RSD = 4'hD;
    localparam logic [3:0] OP_RSE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_IR  = 1'b1;
    localparam logic ACC_ALU  = 1'b0;
    localparam logic ACC_IMM  = 1'b1;

    typedef struct packed {
        logic       en_ir;
        logic       pc_inc;
        logic       pc_ld;
        logic       addr_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       en_acc;
        logic       acc_src;
        logic [2:0] alu_op;
        logic       halted;
    } strobe_t;

    // Opcodes whose operand is fetched from memory and folded into the accumulator
    function automatic logic is_mem_rd_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic is_reserved_op(input logic [3:0] op);
        return (op == OP_RSC) || (op == OP_RSD) || (op == OP_RSE);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational strobe decode from state, opcode, zero and mem_rdy
module ctrl_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_rdy,
    output strobe_t         strb
);

    always_comb begin
        strb = '0;
        case (state)
            ST_FETCH: begin
                strb.mem_rd   = 1'b1;
                strb.addr_sel = ADDR_PC;
            end
            ST_LOAD_IR: begin
                strb.en_ir  = 1'b1;
                strb.pc_inc = 1'b1;
            end
            ST_MEM_RD: begin
                strb.mem_rd   = 1'b1;
                strb.addr_sel = ADDR_IR;
                strb.acc_src  = ACC_ALU;
                // The accumulator captures read data in the cycle memory delivers it
                strb.en_acc   = mem_rdy;
                case (opcode)
                    OP_ADD:  strb.alu_op = ALU_ADD;
                    OP_SUB:  strb.alu_op = ALU_SUB;
                    OP_AND:  strb.alu_op = ALU_AND;
                    OP_OR:   strb.alu_op = ALU_OR;
                    OP_XOR:  strb.alu_op = ALU_XOR;
                    default: strb.alu_op = ALU_PASS;
                endcase
            end
            ST_MEM_WR: begin
                strb.mem_wr   = 1'b1;
                strb.addr_sel = ADDR_IR;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_NOT: begin
                        strb.en_acc = 1'b1;
                        strb.alu_op = ALU_NOT;
                    end
                    OP_LDI: begin
                        strb.en_acc  = 1'b1;
                        strb.acc_src = ACC_IMM;
                    end
                    OP_JMP:  strb.pc_ld = 1'b1;
                    OP_JZ:   strb.pc_ld = zero;
                    default: strb = '0;
                endcase
            end
            ST_HALT: strb.halted = 1'b1;
            default: strb = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - Simple CPU V1 fetch/decode/execute sequencer; ILLEGAL_OP_TRAP_EN enables reserved-opcode trap
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero,
    input  logic               mem_rdy,
    output logic               en_ir,
    output logic               pc_inc,
    output logic               pc_ld,
    output logic               addr_sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               en_acc,
    output logic               acc_src,
    output logic [2:0]         alu_op,
    output logic               halted,
    output logic               illegal,
    output logic [2:0]         state
);

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] opcode;
    strobe_t         strb;
    logic            unused_operand;

    assign opcode         = instr[INSTR_W-1 -: OP_W];
    assign unused_operand = ^instr[INSTR_W-OP_W-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_RST:     state_d = ST_FETCH;
            ST_FETCH:   state_d = mem_rdy ? ST_LOAD_IR : ST_FETCH;
            ST_LOAD_IR: state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_mem_rd_op(opcode)) begin
                    state_d = ST_MEM_RD;
                end else if (opcode == OP_STA) begin
                    state_d = ST_MEM_WR;
                end else if ((opcode == OP_NOT) || (opcode == OP_JMP) ||
                             (opcode == OP_JZ)  || (opcode == OP_LDI)) begin
                    state_d = ST_EXEC;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
                end else if (is_reserved_op(opcode)) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_RD:  state_d = mem_rdy ? ST_FETCH : ST_MEM_RD;
            ST_MEM_WR:  state_d = mem_rdy ? ST_FETCH : ST_MEM_WR;
            ST_EXEC:    state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_FETCH;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic trap_q;

    // Sticky until clr so software can see why the core stopped
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            trap_q <= 1'b0;
        end else if ((state_q == ST_DECODE) && is_reserved_op(opcode)) begin
            trap_q <= 1'b1;
        end
    end

    assign illegal = trap_q;
`else
    assign illegal = 1'b0;
`endif

    ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rdy (mem_rdy),
        .strb    (strb)
    );

    assign en_ir    = strb.en_ir;
    assign pc_inc   = strb.pc_inc;
    assign pc_ld    = strb.pc_ld;
    assign addr_sel = strb.addr_sel;
    assign mem_rd   = strb.mem_rd;
    assign mem_wr   = strb.mem_wr;
    assign en_acc   = strb.en_acc;
    assign acc_src  = strb.acc_src;
    assign alu_op   = strb.alu_op;
    assign halted   = strb.halted;
    assign state    = state_q;

endmodule
